// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the PC generator and instruction memory / control.
// The master modport is the PC generator; the slave modport is the fetch/control side.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            pc_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus4;
  logic            pc_valid;
  logic            misalign_err;
  logic [31:0]     fetch_cnt;

  modport master (
    input  pc_ready, redirect_valid, redirect_target, trap_valid, halt_req, resume,
    output pc_out, pc_plus4, pc_valid, misalign_err, fetch_cnt
  );

  modport slave (
    output pc_ready, redirect_valid, redirect_target, trap_valid, halt_req, resume,
    input  pc_out, pc_plus4, pc_valid, misalign_err, fetch_cnt
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT fetch control with stall-time redirect buffering.
// Define PC_PERF_CNT_EN to build the saturating accepted-fetch counter; otherwise fetch_cnt is 0.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
  input logic       clk,
  input logic       rst_n,
  pc_gen_if.master  bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          r_state, w_state_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic [XLEN-1:0] r_pend_addr, w_pend_addr_next;
  logic            r_pend_valid, w_pend_valid_next;
  logic            r_pend_trap, w_pend_trap_next;
  logic            r_halt_pend, w_halt_pend_next;
  logic            r_misalign;

  logic [XLEN-1:0] w_pc_plus4;
  logic            w_valid, w_accept;
  logic            w_misalign, w_trap_evt, w_redir_evt;

  assign w_pc_plus4  = r_pc + XLEN'(4);
  assign w_valid     = (r_state == RUN);
  assign w_accept    = w_valid & bus.pc_ready;
  // A misaligned redirect is promoted to a trap and loses its own target.
  assign w_misalign  = bus.redirect_valid & (|bus.redirect_target[1:0]);
  assign w_trap_evt  = bus.trap_valid | w_misalign;
  assign w_redir_evt = bus.redirect_valid & ~w_misalign;

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_pend_addr_next  = r_pend_addr;
    w_pend_valid_next = r_pend_valid;
    w_pend_trap_next  = r_pend_trap;
    w_halt_pend_next  = r_halt_pend;

    unique case (r_state)
      BOOT: w_state_next = bus.halt_req ? HALT : RUN;

      RUN: begin
        if (w_accept) begin
          if (w_trap_evt)        w_pc_next = TRAP_VECTOR;
          else if (w_redir_evt)  w_pc_next = bus.redirect_target;
          else if (r_pend_valid) w_pc_next = r_pend_addr;
          else                   w_pc_next = w_pc_plus4;
          w_pend_valid_next = 1'b0;
          w_pend_trap_next  = 1'b0;
          w_halt_pend_next  = 1'b0;
          if (bus.halt_req || r_halt_pend) w_state_next = HALT;
        end else begin
          // Stalled: pc_out holds; a pending trap is never displaced by a redirect.
          if (w_trap_evt) begin
            w_pend_addr_next  = TRAP_VECTOR;
            w_pend_valid_next = 1'b1;
            w_pend_trap_next  = 1'b1;
          end else if (w_redir_evt && !r_pend_trap) begin
            w_pend_addr_next  = bus.redirect_target;
            w_pend_valid_next = 1'b1;
          end
          if (bus.halt_req) w_halt_pend_next = 1'b1;
        end
      end

      HALT: begin
        if (w_trap_evt)       w_pc_next = TRAP_VECTOR;
        else if (w_redir_evt) w_pc_next = bus.redirect_target;
        if (!bus.halt_req && (bus.resume || bus.trap_valid)) w_state_next = RUN;
      end

      default: w_state_next = BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= BOOT;
      r_pc         <= RESET_VECTOR;
      r_pend_addr  <= '0;
      r_pend_valid <= 1'b0;
      r_pend_trap  <= 1'b0;
      r_halt_pend  <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_pend_addr  <= w_pend_addr_next;
      r_pend_valid <= w_pend_valid_next;
      r_pend_trap  <= w_pend_trap_next;
      r_halt_pend  <= w_halt_pend_next;
      r_misalign   <= w_misalign;
    end
  end

`ifdef PC_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_fetch_cnt <= '0;
    else if (w_accept && r_fetch_cnt != '1)  r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end

  assign bus.fetch_cnt = r_fetch_cnt;
`else
  assign bus.fetch_cnt = '0;
`endif

  assign bus.pc_out       = r_pc;
  assign bus.pc_plus4     = w_pc_plus4;
  assign bus.pc_valid     = w_valid;
  assign bus.misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot, stalled redirects, trap priority, misalignment,
// halt/resume, wrap-around, fetch counter and asynchronous reset.
module tb_pc_gen;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_1000),
    .TRAP_VECTOR  (32'h0000_0100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt(input logic [31:0] n);
`ifdef PC_PERF_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] tgt,
                       input logic tv, input logic hr, input logic rs);
    bus.pc_ready        = rdy;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    bus.trap_valid      = tv;
    bus.halt_req        = hr;
    bus.resume          = rs;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #11;
    check("reset_pc",       bus.pc_out,       32'h0000_1000);
    check("reset_plus4",    bus.pc_plus4,     32'h0000_1004);
    check("reset_valid",    bus.pc_valid,     32'h0);
    check("reset_misalign", bus.misalign_err, 32'h0);
    check("reset_cnt",      bus.fetch_cnt,    32'h0);

    @(negedge clk) rst_n = 1'b1;
    #1 check("boot_valid", bus.pc_valid, 32'h0);

    tick(); check("run_valid", bus.pc_valid, 32'h1);
            check("run_pc0",   bus.pc_out,   32'h0000_1000);
    tick(); check("run_pc1",   bus.pc_out,   32'h0000_1004);
    tick(); check("run_pc2",   bus.pc_out,   32'h0000_1008);
            check("cnt_2",     bus.fetch_cnt, exp_cnt(32'd2));

    // Two redirects during a stall: the newer one wins once accepted.
    drive(1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b0);
    tick(); check("stall_hold1", bus.pc_out, 32'h0000_1008);
    drive(1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0, 1'b0);
    tick(); check("stall_hold2", bus.pc_out, 32'h0000_1008);
            check("stall_valid", bus.pc_valid, 32'h1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); check("stall_apply", bus.pc_out, 32'h0000_3000);

    // Trap beats a same-cycle redirect.
    drive(1'b1, 1'b1, 32'h0000_2000, 1'b1, 1'b0, 1'b0);
    tick(); check("trap_prio", bus.pc_out, 32'h0000_0100);

    // Pending trap is not displaced by a later stalled redirect.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); check("ptrap_hold", bus.pc_out, 32'h0000_0100);
    drive(1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b0);
    tick(); check("ptrap_hold2", bus.pc_out, 32'h0000_0100);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); check("ptrap_apply", bus.pc_out, 32'h0000_0100);
            check("cnt_5",       bus.fetch_cnt, exp_cnt(32'd5));

    // Misaligned redirect becomes a trap; error flag lasts one cycle.
    drive(1'b1, 1'b1, 32'h0000_2002, 1'b0, 1'b0, 1'b0);
    tick(); check("mis_pc",   bus.pc_out,       32'h0000_0100);
            check("mis_err1", bus.misalign_err, 32'h1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); check("mis_seq",  bus.pc_out,       32'h0000_0104);
            check("mis_err0", bus.misalign_err, 32'h0);

    // Halt requested during a stall waits for the accept.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick(); check("halt_stall_v1", bus.pc_valid, 32'h1);
    tick(); check("halt_stall_v2", bus.pc_valid, 32'h1);
            check("halt_stall_pc", bus.pc_out,   32'h0000_0104);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick(); check("halt_valid", bus.pc_valid, 32'h0);
            check("halt_pc",    bus.pc_out,   32'h0000_0108);
    drive(1'b1, 1'b1, 32'h0000_4000, 1'b0, 1'b0, 1'b0);
    tick(); check("halt_redir_pc", bus.pc_out,   32'h0000_4000);
            check("halt_redir_v",  bus.pc_valid, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    tick(); check("halt_wins", bus.pc_valid, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick(); check("resume_v",  bus.pc_valid, 32'h1);
            check("resume_pc", bus.pc_out,   32'h0000_4000);

    // Wrap-around of the sequential increment.
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    tick(); check("wrap_pc",    bus.pc_out,   32'hFFFF_FFFC);
            check("wrap_plus4", bus.pc_plus4, 32'h0000_0000);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); check("wrap_next",  bus.pc_out,   32'h0000_0000);

    // Asynchronous reset discards a pending redirect.
    drive(1'b0, 1'b1, 32'h0000_5000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("areset_pc",    bus.pc_out,    32'h0000_1000);
    check("areset_valid", bus.pc_valid,  32'h0);
    check("areset_cnt",   bus.fetch_cnt, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick(); check("reboot_pc0", bus.pc_out,   32'h0000_1000);
            check("reboot_v",   bus.pc_valid, 32'h1);
    tick(); check("reboot_pc1", bus.pc_out,   32'h0000_1004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
